// File: rtl/instr_line_buffer.sv
// instr_line_buffer: small FIFO of I-cache lines feeding up to FETCH_W
// consecutive instructions per cycle to decode, starting at a tracked word
// offset, with a fetch group allowed to span the head line and the next one.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   line_valid_i     cache line offered
//   line_i           cache line data, word 0 in bits [ILEN-1:0]
//   line_ready_o     FIFO can accept a line (count < DEPTH, no pop bypass)
//   redirect_i       flush and restart the stream
//   redirect_off_i   word offset of the first instruction in the next line
//   instr_o          slot k in bits [ILEN*k +: ILEN], invalid slots are zero
//   instr_valid_o    contiguous per-slot valid mask from slot 0
//   instr_ready_i    consumer takes all valid slots this cycle
//   count_o          lines held
module instr_line_buffer #(
    parameter int LINE_LEN = 128,
    parameter int ILEN     = 32,
    parameter int FETCH_W  = 2,
    parameter int DEPTH    = 2,
    localparam int WORDS   = LINE_LEN / ILEN,
    localparam int OFF_W   = $clog2(WORDS),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    line_valid_i,
    input  logic [LINE_LEN-1:0]     line_i,
    output logic                    line_ready_o,
    input  logic                    redirect_i,
    input  logic [OFF_W-1:0]        redirect_off_i,
    output logic [FETCH_W*ILEN-1:0] instr_o,
    output logic [FETCH_W-1:0]      instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [CNT_W-1:0]        count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for avail (up to 2*WORDS) and off+n (up to 2*WORDS-1).
    localparam int AW = OFF_W + 2;
    localparam logic [AW-1:0] WORDS_A = AW'(WORDS);
    localparam logic [AW-1:0] FETCH_A = AW'(FETCH_W);

    logic [LINE_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    head, tail, head_nx, tail_nx;
    logic [CNT_W-1:0]    count;
    logic [OFF_W-1:0]    off;
    logic [AW-1:0]       avail, n, s;
    logic [ILEN-1:0]     hw [WORDS];
    logic [ILEN-1:0]     nw [WORDS];
    logic                push, cons, pop;

    assign head_nx = (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign tail_nx = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;

    for (genvar w = 0; w < WORDS; w++) begin : g_word
        assign hw[w] = mem[head][w*ILEN +: ILEN];
        assign nw[w] = mem[head_nx][w*ILEN +: ILEN];
    end

    // Only the head line and the one behind it are ever visible.
    assign avail = ((count != '0) ? WORDS_A - AW'(off) : '0)
                 + ((count >= CNT_W'(2)) ? WORDS_A : '0);
    assign n     = (avail > FETCH_A) ? FETCH_A : avail;
    assign s     = AW'(off) + n;

    for (genvar k = 0; k < FETCH_W; k++) begin : g_slot
        logic [AW-1:0] idx, wi;
        assign idx = AW'(off) + AW'(k);
        assign wi  = (idx < WORDS_A) ? idx : idx - WORDS_A;
        assign instr_valid_o[k] = AW'(k) < avail;
        assign instr_o[k*ILEN +: ILEN] = !instr_valid_o[k] ? '0 :
                                         (idx < WORDS_A) ? hw[wi[OFF_W-1:0]] : nw[wi[OFF_W-1:0]];
    end

    assign line_ready_o = count < CNT_W'(DEPTH);
    assign count_o      = count;
    assign push         = line_valid_i & line_ready_o & ~redirect_i;
    assign cons         = instr_ready_i & |instr_valid_o & ~redirect_i;
    // FETCH_W <= WORDS, so one consume crosses at most one line boundary.
    assign pop          = cons & (s >= WORDS_A);

    always_ff @(posedge clk_i)
        if (push) mem[tail] <= line_i;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            off   <= '0;
        end else if (redirect_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            off   <= redirect_off_i;
        end else begin
            if (push) tail <= tail_nx;
            if (pop) head <= head_nx;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (cons) off <= OFF_W'(pop ? s - WORDS_A : s);
        end
endmodule

// File: tb/tb_instr_line_buffer.sv
// tb_instr_line_buffer: directed scenarios plus a randomized stream checked against a line-queue model.
module tb_instr_line_buffer;
    localparam int LL = 128, IL = 32, FW = 2, WORDS = 4;

    logic clk = 0, rst_n = 0, line_valid = 0, redirect = 0, instr_ready = 0;
    logic [LL-1:0] line = '0;
    logic [1:0] redirect_off = '0;
    logic line_ready_a, line_ready_b;
    logic [FW*IL-1:0] instr_a, instr_b;
    logic [FW-1:0] valid_a, valid_b;
    logic [1:0] count_a, count_b;
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    instr_line_buffer #(.LINE_LEN(LL), .ILEN(IL), .FETCH_W(FW), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .line_valid_i(line_valid), .line_i(line),
        .line_ready_o(line_ready_a), .redirect_i(redirect), .redirect_off_i(redirect_off),
        .instr_o(instr_a), .instr_valid_o(valid_a), .instr_ready_i(instr_ready), .count_o(count_a));

    instr_line_buffer #(.LINE_LEN(LL), .ILEN(IL), .FETCH_W(FW), .DEPTH(3)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .line_valid_i(line_valid), .line_i(line),
        .line_ready_o(line_ready_b), .redirect_i(redirect), .redirect_off_i(redirect_off),
        .instr_o(instr_b), .instr_valid_o(valid_b), .instr_ready_i(instr_ready), .count_o(count_b));

    function automatic logic [LL-1:0] mk(input logic [31:0] base);
        logic [LL-1:0] l;
        for (int i = 0; i < WORDS; i++) l[i*IL +: IL] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [IL-1:0] wd(input logic [LL-1:0] l, input int i);
        return l[i*IL +: IL];
    endfunction

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redir(input logic [1:0] o);
        redirect = 1; redirect_off = o;
        cyc();
        redirect = 0;
    endtask

    task automatic push(input logic [LL-1:0] l);
        line_valid = 1; line = l;
        cyc();
        line_valid = 0;
    endtask

    task automatic take;
        instr_ready = 1;
        cyc();
        instr_ready = 0;
    endtask

    logic [LL-1:0] la, lb, lc, ld;
    initial begin
        la = mk(32'hA000_0000);
        lb = mk(32'hB000_0000);
        lc = mk(32'hC000_0000);
        ld = mk(32'hD000_0000);
    end

    task automatic test_reset;
        #12;
        checks++; if (valid_a !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b want 00", valid_a); end
        checks++; if (instr_a !== '0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr_a); end
        checks++; if (count_a !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count_a); end
        checks++; if (line_ready_a !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", line_ready_a); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        redir(2'd0);
        push(la);
        checks++; if (valid_a !== 2'b11) begin fails++; $display("FAIL basic_valid0: got %b want 11", valid_a); end
        checks++; if (instr_a !== {wd(la,1), wd(la,0)}) begin fails++; $display("FAIL basic_instr0: got %h want %h", instr_a, {wd(la,1), wd(la,0)}); end
        take();
        checks++; if (instr_a !== {wd(la,3), wd(la,2)}) begin fails++; $display("FAIL basic_instr1: got %h want %h", instr_a, {wd(la,3), wd(la,2)}); end
        take();
        checks++; if (valid_a !== 2'b00) begin fails++; $display("FAIL basic_valid_end: got %b want 00", valid_a); end
        checks++; if (count_a !== 2'd0) begin fails++; $display("FAIL basic_count_end: got %0d want 0", count_a); end
    endtask

    task automatic test_crossing;
        redir(2'd3);
        push(la);
        push(lb);
        checks++; if (count_a !== 2'd2) begin fails++; $display("FAIL cross_count2: got %0d want 2", count_a); end
        checks++; if (valid_a !== 2'b11) begin fails++; $display("FAIL cross_valid: got %b want 11", valid_a); end
        checks++; if (instr_a !== {wd(lb,0), wd(la,3)}) begin fails++; $display("FAIL cross_instr0: got %h want %h", instr_a, {wd(lb,0), wd(la,3)}); end
        take();
        checks++; if (count_a !== 2'd1) begin fails++; $display("FAIL cross_count1: got %0d want 1", count_a); end
        checks++; if (instr_a !== {wd(lb,2), wd(lb,1)}) begin fails++; $display("FAIL cross_instr1: got %h want %h", instr_a, {wd(lb,2), wd(lb,1)}); end
    endtask

    task automatic test_tail;
        redir(2'd3);
        push(la);
        checks++; if (valid_a !== 2'b01) begin fails++; $display("FAIL tail_valid: got %b want 01", valid_a); end
        checks++; if (instr_a !== {32'h0, wd(la,3)}) begin fails++; $display("FAIL tail_instr: got %h want %h", instr_a, {32'h0, wd(la,3)}); end
        take();
        checks++; if (count_a !== 2'd0) begin fails++; $display("FAIL tail_count: got %0d want 0", count_a); end
        checks++; if (valid_a !== 2'b00) begin fails++; $display("FAIL tail_valid_end: got %b want 00", valid_a); end
    endtask

    task automatic test_full;
        redir(2'd0);
        push(la);
        push(lb);
        checks++; if (line_ready_a !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", line_ready_a); end
        push(lc);
        checks++; if (count_a !== 2'd2) begin fails++; $display("FAIL full_count: got %0d want 2", count_a); end
        take();
        checks++; if (line_ready_a !== 1'b0) begin fails++; $display("FAIL full_ready_mid: got %b want 0", line_ready_a); end
        take();
        checks++; if (line_ready_a !== 1'b1) begin fails++; $display("FAIL full_ready_after: got %b want 1", line_ready_a); end
        checks++; if (instr_a !== {wd(lb,1), wd(lb,0)}) begin fails++; $display("FAIL full_instr_b: got %h want %h", instr_a, {wd(lb,1), wd(lb,0)}); end
    endtask

    task automatic test_redirect;
        redir(2'd0);
        push(la);
        push(lb);
        take();
        redirect = 1; redirect_off = 2'd1; line_valid = 1; line = lc; instr_ready = 1;
        cyc();
        redirect = 0; line_valid = 0; instr_ready = 0;
        checks++; if (count_a !== 2'd0) begin fails++; $display("FAIL redir_count: got %0d want 0", count_a); end
        checks++; if (valid_a !== 2'b00) begin fails++; $display("FAIL redir_valid: got %b want 00", valid_a); end
        push(ld);
        checks++; if (instr_a !== {wd(ld,2), wd(ld,1)}) begin fails++; $display("FAIL redir_instr: got %h want %h", instr_a, {wd(ld,2), wd(ld,1)}); end
        checks++; if (count_a !== 2'd1) begin fails++; $display("FAIL redir_count1: got %0d want 1", count_a); end
    endtask

    task automatic test_async_reset;
        redir(2'd0);
        push(la);
        push(lb);
        checks++; if (valid_a !== 2'b11) begin fails++; $display("FAIL areset_pre_valid: got %b want 11", valid_a); end
        #2 rst_n = 0;
        #1;
        checks++; if (valid_a !== 2'b00) begin fails++; $display("FAIL areset_valid: got %b want 00", valid_a); end
        checks++; if (instr_a !== '0) begin fails++; $display("FAIL areset_instr: got %h want 0", instr_a); end
        checks++; if (count_a !== 2'd0) begin fails++; $display("FAIL areset_count: got %0d want 0", count_a); end
        checks++; if (line_ready_a !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b want 1", line_ready_a); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Model: each instance holds an ordered list of lines and a word offset
    // into the first; visible words are the stream from that offset across
    // at most the first two lines.
    logic [LL-1:0] ml [2][3];
    int mc [2];
    int mo [2];
    int dep [2] = '{2, 3};

    task automatic model_out(input int d, output logic [FW-1:0] ev, output logic [FW*IL-1:0] ei, output int nv);
        ev = '0; ei = '0; nv = 0;
        for (int k = 0; k < FW; k++) begin
            int p, li;
            p = mo[d] + k;
            li = p / WORDS;
            if (li < mc[d] && li < 2) begin
                ev[k] = 1'b1;
                ei[k*IL +: IL] = wd(ml[d][li], p % WORDS);
                nv++;
            end
        end
    endtask

    task automatic test_random;
        logic [FW-1:0] ev, gv;
        logic [FW*IL-1:0] ei, gi;
        logic [1:0] gc;
        logic gr;
        int nv;
        mc = '{0, 0};
        mo = '{0, 0};
        for (int c = 0; c < 600; c++) begin
            line_valid = $urandom_range(0, 9) < 6;
            line = {$urandom, $urandom, $urandom, $urandom};
            redirect = (c == 0) || ($urandom_range(0, 19) == 0);
            redirect_off = 2'($urandom);
            instr_ready = 1'($urandom);
            for (int d = 0; d < 2; d++) begin
                model_out(d, ev, ei, nv);
                gv = d ? valid_b : valid_a;
                gi = d ? instr_b : instr_a;
                gc = d ? count_b : count_a;
                gr = d ? line_ready_b : line_ready_a;
                checks++; if (gv !== ev) begin fails++; $display("FAIL rand_valid d%0d cyc%0d: got %b want %b", d, c, gv, ev); end
                checks++; if (gi !== ei) begin fails++; $display("FAIL rand_instr d%0d cyc%0d: got %h want %h", d, c, gi, ei); end
                checks++; if (gc !== 2'(mc[d])) begin fails++; $display("FAIL rand_count d%0d cyc%0d: got %0d want %0d", d, c, gc, mc[d]); end
                checks++; if (gr !== (mc[d] < dep[d])) begin fails++; $display("FAIL rand_ready d%0d cyc%0d: got %b want %b", d, c, gr, mc[d] < dep[d]); end
                checks++; if (gv != 0 && gc == 0) begin fails++; $display("FAIL rand_valid_empty d%0d cyc%0d: valid %b with count 0", d, c, gv); end
                checks++; if (int'(gc) > dep[d]) begin fails++; $display("FAIL rand_count_max d%0d cyc%0d: got %0d max %0d", d, c, gc, dep[d]); end
            end
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (redirect) begin
                    mc[d] = 0;
                    mo[d] = int'(redirect_off);
                end else begin
                    bit pushed;
                    model_out(d, ev, ei, nv);
                    pushed = line_valid && mc[d] < dep[d];
                    if (instr_ready && nv > 0) begin
                        mo[d] += nv;
                        if (mo[d] >= WORDS) begin
                            mo[d] -= WORDS;
                            for (int j = 0; j < 2; j++) ml[d][j] = ml[d][j+1];
                            mc[d]--;
                        end
                    end
                    if (pushed) begin
                        ml[d][mc[d]] = line;
                        mc[d]++;
                    end
                end
            end
            @(negedge clk);
        end
        line_valid = 0; redirect = 0; instr_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crossing();
        test_tail();
        test_full();
        test_redirect();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/instr_line_buffer.md
Name: instr_line_buffer

Overview:
- Parametrised successor to the single-instruction line/PC selector in fetch.
- Holds up to DEPTH instruction-cache lines in a small FIFO.
- Extracts up to FETCH_W consecutive instructions per cycle starting at a tracked word offset. A fetch group may span the head line and the next line.
- Sits between the I-cache output and decode, and replaces the cache_out/line_reg/line_bak muxing with valid/ready handshakes on both sides.

Parameters:
- LINE_LEN, ICACHE_LINE_LEN (128): cache line width in bits.
- ILEN, ILEN (32): instruction width in bits; LINE_LEN must be a multiple of ILEN.
- FETCH_W, 2: instruction slots per cycle; 1 <= FETCH_W <= WORDS.
- DEPTH, 2: line FIFO entries; must be >= 2.
- WORDS (derived): LINE_LEN/ILEN.
- OFF_W (derived): $clog2(WORDS).
- CNT_W (derived): $clog2(DEPTH+1).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- line_valid_i  in  1  cache line offered.
- line_i  in  LINE_LEN  cache line data, word 0 in bits [ILEN-1:0].
- line_ready_o  out  1  FIFO can accept a line.
- redirect_i  in  1  flush and restart the stream.
- redirect_off_i  in  OFF_W  word offset of the first instruction in the next pushed line.
- instr_o  out  FETCH_W*ILEN  slot k in bits [ILEN*k +: ILEN].
- instr_valid_o  out  FETCH_W  per-slot valid; always a contiguous mask from slot 0.
- instr_ready_i  in  1  consumer takes all valid slots this cycle.
- count_o  out  CNT_W  lines held.

Behaviour:
- State registers:
  - FIFO storage: DEPTH x LINE_LEN.
  - head pointer and tail pointer, each wrapping modulo DEPTH.
  - count.
  - off, OFF_W bits: word offset inside the head line.
- Reset (asynchronous, while rst_n_i=0): count=0, off=0, pointers=0. Resulting outputs: instr_valid_o=0, instr_o=0, line_ready_o=1, count_o=0. FIFO data is not reset.
- Push:
  - Condition: line_valid_i & line_ready_o & ~redirect_i.
  - line_ready_o = (count < DEPTH). A pop in the same cycle does not raise ready (no full bypass).
  - The pushed line is written at tail and becomes visible on the outputs the following cycle (1-cycle latency).
- Availability:
  - avail = (count>=1 ? WORDS-off : 0) + (count>=2 ? WORDS : 0).
  - Slot k is valid iff k < avail.
  - Slot k data:
    - off+k < WORDS: head word off+k.
    - otherwise: word off+k-WORDS of entry head+1.
  - Invalid slots drive zero.
- Consume:
  - Condition: instr_ready_i & |instr_valid_o & ~redirect_i.
  - n = popcount(instr_valid_o).
  - s = off + n, computed with OFF_W+1 bits.
  - If s >= WORDS: pop head, head++, off = s - WORDS.
  - Otherwise: off = s.
  - At most one pop per cycle; FETCH_W <= WORDS guarantees this.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Redirect has priority over everything:
  - On redirect_i: count=0, head=tail=0, off=redirect_off_i.
  - A line push in the same cycle is dropped.
  - A consumer handshake in the same cycle has no effect.
  - instr_valid_o returns 0 the next cycle.
- redirect_off_i applies only to the first line after a redirect; it is held in off while the FIFO is empty.
- Consumer-side expectations (assertions in the bench):
  - instr_valid_o nonzero only when count>=1.
  - count <= DEPTH.
  - Pointer wrap at DEPTH is exercised with DEPTH=3.

Test Plan:
Default parameters (WORDS=4, FETCH_W=2, DEPTH=2). Notation: instr_o is written {slot1,slot0}.
1. Basic stream: redirect off=0, then push L0={A3,A2,A1,A0}.
   - Next cycle: valid=2'b11, instr_o={A1,A0}.
   - Accept: {A3,A2}.
   - Accept: valid=00, count_o=0.
2. Line crossing: redirect off=3, push L0 then L1={B3..B0}.
   - Once count_o=2: valid=11, instr_o={B0,A3}.
   - Accept: L0 popped, off=1, count_o=1, instr_o={B2,B1}.
3. Tail fragment: redirect off=3, push L0 only.
   - valid=01, slot0=A3, slot1=0.
   - Accept: count_o=0, valid=00.
4. Full/backpressure: push L0 and L1 with instr_ready_i=0.
   - line_ready_o=0; a third offered line is not accepted and count_o stays 2.
   - Consume 4 words: line_ready_o=1.
5. Redirect collision: count_o=2, off=2, and in the same cycle redirect off=1, line_valid_i=1, instr_ready_i=1.
   - Next cycle: count_o=0, valid=00.
   - Next push L2: instr_o={L2w2,L2w1}.
6. Async reset mid-operation: assert rst_n_i with count_o=2 and valid=11.
   - Immediately, without a clock edge: valid=00, instr_o=0, count_o=0, line_ready_o=1.
